// File: rtl/dct_block_packer.sv
// Row-to-block packer feeding the 4x4 DCT: gathers four 4-pixel rows into one 128-bit block,
// double-buffers two blocks and checks row framing against the last-row marker.
module dct_block_packer #(
   parameter int unsigned PIX_WIDTH = 8,
   localparam int unsigned ROW_WIDTH = 4 * PIX_WIDTH,
   localparam int unsigned DATA_WIDTH = 4 * ROW_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_valid,
   output logic                  i_ready,
   input  logic [ROW_WIDTH-1:0]  i_data,
   input  logic                  i_last,
   output logic                  o_valid,
   input  logic                  o_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_err
);

   logic [ROW_WIDTH-1:0] slot [2][4];
   logic                 wp;
   logic                 rp;
   logic [1:0]           cnt;
   logic [1:0]           row;
   logic                 err;

   logic in_hs;
   logic out_hs;
   logic last_row;
   logic complete;
   logic abort;

   // Ready depends only on the block count, so no path from o_ready reaches i_ready.
   assign i_ready  = (cnt != 2'd2);
   assign o_valid  = (cnt != 2'd0);
   assign o_err    = err;
   assign o_data   = {slot[rp][3], slot[rp][2], slot[rp][1], slot[rp][0]};

   assign in_hs    = i_valid & i_ready;
   assign out_hs   = o_valid & o_ready;
   assign last_row = (row == 2'd3);
   assign complete = in_hs & last_row;
   assign abort    = in_hs & i_last & ~last_row;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 2; s++) begin
            for (int r = 0; r < 4; r++) begin
               slot[s][r] <= '0;
            end
         end
         wp  <= 1'b0;
         rp  <= 1'b0;
         cnt <= 2'd0;
         row <= 2'd0;
         err <= 1'b0;
      end else begin
         if (in_hs) begin
            slot[wp][row] <= i_data;
            // An aborted partial block restarts at row 0; its stale rows get overwritten.
            row <= (complete | abort) ? 2'd0 : row + 2'd1;
         end
         if (complete) begin
            wp <= ~wp;
         end
         if (out_hs) begin
            rp <= ~rp;
         end
         if (complete & ~out_hs) begin
            cnt <= cnt + 2'd1;
         end else if (~complete & out_hs) begin
            cnt <= cnt - 2'd1;
         end
         // Framing error: marker missing on row 3, or present on rows 0..2.
         err <= in_hs & (i_last ^ last_row);
      end
   end

endmodule

// File: doc/dct_block_packer.md
# dct_block_packer

Upstream feeder for the 4x4 2D DCT datapath. It accepts one 4-pixel row per handshake and assembles four consecutive rows into one 128-bit block. It holds up to two blocks in a ping-pong buffer and presents each finished block on a valid/ready output that drives the block-wide pipeline register stage. It also checks row framing against a last-row marker.

## Interface
- PIX_WIDTH, 8, bits per pixel
- ROW_WIDTH, 4*PIX_WIDTH (32), bits per input row; derived, do not override
- DATA_WIDTH, 4*ROW_WIDTH (128), bits per output block; derived, do not override

Ports:
- clk  input  1  sole clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- i_valid  input  1  input row valid
- i_ready  output  1  packer can accept a row
- i_data  input  ROW_WIDTH  row pixels; pixel j at bits [PIX_WIDTH*j +: PIX_WIDTH]
- i_last  input  1  marks row 3 (last row) of a block; qualified by i_valid
- o_valid  output  1  complete block available
- o_ready  input  1  downstream accepts block
- o_data  output  DATA_WIDTH  block; row k at bits [ROW_WIDTH*k +: ROW_WIDTH]
- o_err  output  1  one-cycle framing-error pulse

## Operation
- Input handshake: i_valid & i_ready. Output handshake: o_valid & o_ready.
- Storage is two block slots (slot0, slot1), a write pointer wp, a read pointer rp, a 2-bit block count cnt (0..2) and a 2-bit row counter row.
- On an input handshake, i_data is written into slot[wp] at row position row, and row increments.
- Row 3 accepted with i_last=1 completes the block normally: row←0, wp toggles, cnt increments.
- Row 3 accepted with i_last=0 still completes the block in the same way. o_err pulses.
- Row 0..2 accepted with i_last=1 is early termination. The partial block is discarded (row←0; wp and cnt unchanged) and o_err pulses. Stale row data in the slot is overwritten by the next block.
- o_valid = (cnt != 0). o_data = slot[rp], driven directly from slot registers with no output mux beyond the slot select.
- On an output handshake, rp toggles and cnt decrements.
- A block completion and an output handshake in the same cycle leave cnt unchanged, and both pointers move.
- i_ready = (cnt != 2). It is a function of registered state only, with no combinational path from o_ready. A row offered while cnt==2 waits even if o_ready=1 that cycle.
- No arithmetic on pixel data. Bits pass through unmodified (level shift is done downstream).

## Timing
- Reset values: i_ready=1, o_valid=0, o_err=0, o_data=0 (all slots cleared), cnt=0, row=0, wp=0, rp=0.
- Reset asserted mid-block or with blocks pending drops all partial and pending blocks. No output handshake completes in a reset cycle.
- Latency: o_valid rises the cycle after the row-3 input handshake. o_data is stable from that cycle until the output handshake.
- While o_valid=1 and o_ready=0, o_valid and o_data hold.
- Sustained throughput: 1 row/cycle in, 1 block per 4 cycles out, with no bubbles when o_ready=1.
- With o_ready stuck low, the packer accepts exactly 8 rows, then i_ready=0. i_ready returns to 1 the cycle after the first output handshake.
- o_err is high for exactly the cycle following the offending input handshake. It is never high during or directly after reset.

## Test plan
- Reset then rows 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C (i_last on the 4th), o_ready=1 -> o_valid one cycle after the 4th handshake; o_data=0x0F0E0D0C_0B0A0908_07060504_03020100; o_err stays 0.
- o_ready=0, stream 12 back-to-back rows -> 8 rows accepted, i_ready low from the cycle after the 8th. Raise o_ready -> blocks 1, 2, 3 emitted in order on consecutive-capable cycles; no data loss.
- i_last asserted on row 1 (2nd row) -> o_err pulse 1 cycle; no o_valid. The next 4 correctly framed rows produce one block containing only those rows.
- Row 3 without i_last -> block still emitted and o_err pulses once. The following block frames from row 0.
- Completion and output handshake in the same cycle with cnt=1 -> cnt stays 1 and o_data switches to the new block the next cycle. Random o_ready/i_valid toggling over 1000 blocks -> scoreboard exact match.
- Reset asserted after 2 rows of a block and with 1 block pending -> next cycle o_valid=0, i_ready=1, o_data=0. The following 4 rows form a clean block.
